// File: rtl/stream_width_packer_pkg.sv
// Shared stream helpers: beat-count width and lane zero-fill select.
// Reused by the matching unpacker.
package stream_pkg;

  function automatic int beats_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // 1 when lane holds real data for a word whose last written lane is cnt
  function automatic logic lane_kept(input int lane, input int cnt);
    return (lane <= cnt);
  endfunction

endpackage

// File: rtl/stream_width_packer_if.sv
// Narrow-in / wide-out stream bundle around the packer.
// The slave modport is the packer's view; master is the producer/consumer side.
interface stream_width_packer_if
  import stream_pkg::*;
#(
  parameter int IN_WIDTH = 4,
  parameter int RATIO    = 4
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int BEATS_W   = beats_w(RATIO);

  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_last;
  logic [BEATS_W-1:0]   out_beats;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_beats
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_beats
  );
endinterface

// File: rtl/stream_width_packer.sv
// Packs IN_WIDTH-bit beats LSB-first into IN_WIDTH*RATIO-bit words; in_last
// flushes a zero-padded partial word tagged with its beat count.
module stream_width_packer
  import stream_pkg::*;
#(
  parameter int IN_WIDTH = 4,
  parameter int RATIO    = 4
)(
  input logic clk,
  input logic rst,
  stream_width_packer_if.slave bus
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int BEATS_W   = beats_w(RATIO);
  localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [OUT_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic [BEATS_W-1:0]   r_out_beats;

  logic                 w_in_ready;
  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_complete;
  logic [OUT_WIDTH-1:0] w_merged;

  // Single combinational level from out_ready; a draining word frees the slot.
  assign w_in_ready = !rst && (!r_out_valid || bus.out_ready);
  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_out_xfer = r_out_valid && bus.out_ready;
  assign w_complete = w_in_xfer && ((r_cnt == CNT_W'(RATIO - 1)) || bus.in_last);

  // Current beat dropped into lane cnt; lanes above cnt forced to zero.
  always_comb begin
    w_merged = '0;
    for (int l = 0; l < RATIO; l++) begin
      if (lane_kept(l, int'(r_cnt))) begin
        if (l == int'(r_cnt))
          w_merged[l*IN_WIDTH +: IN_WIDTH] = bus.in_data;
        else
          w_merged[l*IN_WIDTH +: IN_WIDTH] = r_acc[l*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_beats <= '0;
    end else if (w_complete) begin
      r_out_data  <= w_merged;
      r_out_beats <= BEATS_W'(r_cnt) + BEATS_W'(1);
      r_out_last  <= bus.in_last;
      r_out_valid <= 1'b1;
      r_cnt       <= '0;
      r_acc       <= '0;
    end else begin
      if (w_in_xfer) begin
        r_acc <= w_merged;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_out_xfer)
        r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_beats = r_out_beats;

endmodule

// File: tb/tb_stream_width_packer.sv
// Bench for stream_width_packer: directed steps plus random traffic scored
// against a beat-list reference model; a second RATIO=1 instance is checked too.
module tb_stream_width_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_width_packer_if #(.IN_WIDTH(4), .RATIO(4)) ifa ();
  stream_width_packer_if #(.IN_WIDTH(8), .RATIO(1)) ifb ();

  stream_width_packer #(.IN_WIDTH(4), .RATIO(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  stream_width_packer #(.IN_WIDTH(8), .RATIO(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct {
    logic [15:0] data;
    int          beats;
    bit          last;
  } word_t;

  int          checks = 0;
  int          errors = 0;
  word_t       exp_q[$];
  logic [15:0] part_word = '0;
  int          part_n = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data;
  logic [2:0]  prev_beats;
  logic        prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: collect beats, emit a word at 4 beats or on last.
  task automatic model_push(input logic [3:0] d, input logic l);
    part_word = part_word | (16'(d) << (4 * part_n));
    part_n++;
    if (part_n == 4 || l) begin
      exp_q.push_back('{data: part_word, beats: part_n, last: l});
      part_n = 0;
      part_word = '0;
    end
  endtask

  task automatic score();
    word_t w;
    if (exp_q.size() == 0) begin
      check("unexpected_word", 32'(ifa.out_data), 32'hFFFF_FFFF);
    end else begin
      w = exp_q.pop_front();
      check("word_data", 32'(ifa.out_data), 32'(w.data));
      check("word_beats", 32'(ifa.out_beats), 32'(w.beats));
      check("word_last", 32'(ifa.out_last), 32'(w.last));
    end
  endtask

  // Called at a negedge with inputs already driven; samples, then advances one cycle.
  task automatic tick(output bit accepted);
    #1;
    accepted = 0;
    if (prev_stall) begin
      check("hold_data", 32'(ifa.out_data), 32'(prev_data));
      check("hold_beats", 32'(ifa.out_beats), 32'(prev_beats));
      check("hold_last", 32'(ifa.out_last), 32'(prev_last));
    end
    if (rst) begin
      part_n = 0;
      part_word = '0;
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (ifa.out_valid && ifa.out_ready) score();
      if (ifa.in_valid && ifa.in_ready) begin
        accepted = 1;
        model_push(ifa.in_data, ifa.in_last);
      end
      prev_stall = ifa.out_valid && !ifa.out_ready;
      prev_data  = ifa.out_data;
      prev_beats = ifa.out_beats;
      prev_last  = ifa.out_last;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    bit a = 0;
    int n = 0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    ifa.in_last  = l;
    while (!a && n < 40) begin
      tick(a);
      n++;
    end
    ifa.in_valid = 1'b0;
    ifa.in_last  = 1'b0;
    if (!a) check("send_timeout", 32'(a), 32'd1);
  endtask

  initial begin
    bit a;
    ifa.in_valid = 0; ifa.in_data = '0; ifa.in_last = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.in_last = 0; ifb.out_ready = 0;
    @(negedge clk);

    // Reset with a beat offered: nothing accepted, outputs zero
    ifa.in_valid = 1; ifa.in_data = 4'h3;
    tick(a);
    #1;
    check("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_out_data", 32'(ifa.out_data), 32'd0);
    check("rst_out_beats", 32'(ifa.out_beats), 32'd0);
    check("rst_out_last", 32'(ifa.out_last), 32'd0);
    check("rst_b_out_valid", 32'(ifb.out_valid), 32'd0);
    ifa.in_valid = 0;
    rst = 0;
    #1;
    check("release_in_ready", 32'(ifa.in_ready), 32'd1);

    // Full word
    ifa.out_ready = 1;
    send(4'hD, 0); send(4'hC, 0); send(4'hB, 0); send(4'hA, 0);
    #1;
    check("full_valid", 32'(ifa.out_valid), 32'd1);
    check("full_data", 32'(ifa.out_data), 32'hABCD);
    check("full_beats", 32'(ifa.out_beats), 32'd4);
    check("full_last", 32'(ifa.out_last), 32'd0);

    // Partial flush, then a full word with no stale lanes
    send(4'h5, 0); send(4'h5, 1);
    #1;
    check("flush_data", 32'(ifa.out_data), 32'h0055);
    check("flush_beats", 32'(ifa.out_beats), 32'd2);
    check("flush_last", 32'(ifa.out_last), 32'd1);
    send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
    #1;
    check("refill_data", 32'(ifa.out_data), 32'h4321);
    tick(a);

    // Backpressure
    ifa.out_ready = 0;
    send(4'hD, 0); send(4'hC, 0); send(4'hB, 0); send(4'hA, 0);
    ifa.in_valid = 1; ifa.in_data = 4'h1; ifa.in_last = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 32'(ifa.in_ready), 32'd0);
      check("bp_out_data", 32'(ifa.out_data), 32'hABCD);
      check("bp_out_valid", 32'(ifa.out_valid), 32'd1);
      tick(a);
    end
    ifa.out_ready = 1;
    #1;
    check("bp_release_ready", 32'(ifa.in_ready), 32'd1);
    tick(a);
    check("bp_release_accept", 32'(a), 32'd1);
    ifa.in_valid = 0;
    send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
    tick(a);

    // Back-to-back single-beat packets
    for (int i = 0; i < 8; i++) begin
      ifa.in_valid = 1; ifa.in_data = 4'($urandom); ifa.in_last = 1;
      #1;
      if (i > 0) begin
        check("single_valid", 32'(ifa.out_valid), 32'd1);
        check("single_beats", 32'(ifa.out_beats), 32'd1);
      end
      tick(a);
      check("single_accept", 32'(a), 32'd1);
    end
    ifa.in_valid = 0; ifa.in_last = 0;
    tick(a);

    // Reset mid-word
    send(4'h1, 0); send(4'h2, 0);
    rst = 1; ifa.in_valid = 1; ifa.in_data = 4'hF;
    #1;
    check("midrst_in_ready", 32'(ifa.in_ready), 32'd0);
    tick(a);
    rst = 0; ifa.in_valid = 0;
    #1;
    check("midrst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("midrst_out_data", 32'(ifa.out_data), 32'd0);
    check("midrst_out_beats", 32'(ifa.out_beats), 32'd0);
    send(4'h7, 0); send(4'h8, 0); send(4'h9, 0); send(4'hA, 0);
    #1;
    check("midrst_word", 32'(ifa.out_data), 32'hA987);
    check("midrst_beats", 32'(ifa.out_beats), 32'd4);
    tick(a);

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      ifa.in_valid  = ($urandom_range(0, 3) != 0);
      ifa.in_data   = 4'($urandom);
      ifa.in_last   = ($urandom_range(0, 4) == 0);
      ifa.out_ready = ($urandom_range(0, 9) < 7);
      tick(a);
    end
    ifa.out_ready = 1;
    send(4'($urandom), 1);
    tick(a); tick(a);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    // RATIO = 1, IN_WIDTH = 8
    ifb.out_ready = 1;
    ifb.in_valid = 1; ifb.in_data = 8'h55;
    #1;
    check("r1_in_ready", 32'(ifb.in_ready), 32'd1);
    tick(a);
    ifb.in_data = 8'hF0;
    #1;
    check("r1_valid0", 32'(ifb.out_valid), 32'd1);
    check("r1_data0", 32'(ifb.out_data), 32'h55);
    check("r1_beats0", 32'(ifb.out_beats), 32'd1);
    check("r1_last0", 32'(ifb.out_last), 32'd0);
    tick(a);
    ifb.in_valid = 0;
    #1;
    check("r1_valid1", 32'(ifb.out_valid), 32'd1);
    check("r1_data1", 32'(ifb.out_data), 32'hF0);
    check("r1_beats1", 32'(ifb.out_beats), 32'd1);
    tick(a);
    #1;
    check("r1_idle", 32'(ifb.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
